// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the PIPE PowerDown/Rate/receiver-detect sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [3:0] {
        PD_P0  = 4'd0,
        PD_P0S = 4'd1,
        PD_P1  = 4'd2,
        PD_P2  = 4'd3
    } pwr_state_e;

    typedef enum logic [1:0] {
        OP_POWER  = 2'd0,
        OP_RATE   = 2'd1,
        OP_DETECT = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_ERR_ARG   = 2'd1,
        ST_ERR_STATE = 2'd2,
        ST_TIMEOUT   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        RST_WAIT  = 3'd0,
        IDLE      = 3'd1,
        WAIT_PWR  = 3'd2,
        WAIT_RATE = 3'd3,
        WAIT_DET  = 3'd4,
        RESP      = 3'd5
    } fsm_state_e;

    localparam logic [2:0] RX_STATUS_DET = 3'b011;
    localparam logic [3:0] PD_RESET      = 4'h2;
    localparam logic [3:0] RATE_RESET    = 4'h0;
    localparam logic [3:0] ELEC_IDLE_ALL = 4'hF;

endpackage

// File: rtl/pipe_pwr_rate_ctrl_if.sv
// Command/response bundle between the LTSSM (master) and the PIPE sequencer (slave).
interface pipe_pwr_rate_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_arg;
    logic       done;
    logic [1:0] done_status;
    logic       detect_result;

    modport master (
        output req_valid, req_op, req_arg,
        input  req_ready, done, done_status, detect_result
    );

    modport slave (
        input  req_valid, req_op, req_arg,
        output req_ready, done, done_status, detect_result
    );
endinterface

// File: rtl/pipe_ctrl_timer.sv
// Handshake watchdog: terminal-count down-counter, reloaded while clear is high.
// Only instantiated when PIPE_PWR_RATE_CTRL_TIMEOUT_EN is defined.
module pipe_ctrl_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Terminal count is the LIMIT-th waiting cycle after the wait began.
    assign expired = enable && (count == '0);
endmodule

// File: rtl/pipe_pwr_rate_ctrl.sv
// MAC-side sequencer for PIPE PowerDown, Rate and receiver detect.
// Optional handshake watchdog enabled by macro PIPE_PWR_RATE_CTRL_TIMEOUT_EN.
//
// state     | meaning
// RST_WAIT  | PHY still holding phy_status after reset
// IDLE      | ready for a command
// WAIT_PWR  | PowerDown changed, waiting for phy_status
// WAIT_RATE | Rate changed, TxElecIdle forced, waiting for phy_status
// WAIT_DET  | TxDetectRx asserted, waiting for phy_status
// RESP      | done pulse with status; can accept the next command
module pipe_pwr_rate_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_RATE       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_pwr_rate_ctrl_if.slave  req,
    input  logic [3:0]           mac_tx_elec_idle,
    input  logic                 phy_status,
    input  logic [2:0]           rx_status,
    output logic [3:0]           power_down,
    output logic [3:0]           rate,
    output logic                 tx_detect_rx,
    output logic [3:0]           tx_elec_idle
);
    localparam logic [3:0] MAX_RATE_L = 4'(MAX_RATE);

    fsm_state_e state;
    status_e    status_q;
    logic       ready_q;
    logic       done_q;
    logic       detect_q;

    op_e  op;
    logic arg_bad;
    logic state_bad;
    logic no_op;
    logic timeout;

    always_comb begin
        op        = op_e'(req.req_op);
        arg_bad   = (op == OP_RSVD)
                 || (op == OP_POWER && req.req_arg > 4'd3)
                 || (op == OP_RATE  && req.req_arg > MAX_RATE_L);
        state_bad = (op == OP_RATE   && power_down > PD_P0S)
                 || (op == OP_DETECT && power_down != PD_P1);
        no_op     = (op == OP_POWER && req.req_arg == power_down)
                 || (op == OP_RATE  && req.req_arg == rate);
    end

`ifdef PIPE_PWR_RATE_CTRL_TIMEOUT_EN
    logic in_wait;
    logic expired;

    assign in_wait = (state == WAIT_PWR) || (state == WAIT_RATE) || (state == WAIT_DET);

    pipe_ctrl_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    assign timeout = expired;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RST_WAIT;
            status_q     <= ST_OK;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            detect_q     <= 1'b0;
            power_down   <= PD_RESET;
            rate         <= RATE_RESET;
            tx_detect_rx <= 1'b0;
            tx_elec_idle <= ELEC_IDLE_ALL;
        end else begin
            done_q       <= 1'b0;
            tx_elec_idle <= mac_tx_elec_idle;
            case (state)
                RST_WAIT: begin
                    if (!phy_status) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE, RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    if (req.req_valid) begin
                        if (arg_bad || state_bad || no_op) begin
                            state    <= RESP;
                            done_q   <= 1'b1;
                            status_q <= arg_bad ? ST_ERR_ARG : (state_bad ? ST_ERR_STATE : ST_OK);
                        end else begin
                            ready_q <= 1'b0;
                            case (op)
                                OP_POWER: begin
                                    power_down <= req.req_arg;
                                    state      <= WAIT_PWR;
                                end
                                OP_RATE: begin
                                    rate         <= req.req_arg;
                                    tx_elec_idle <= ELEC_IDLE_ALL;
                                    state        <= WAIT_RATE;
                                end
                                default: begin
                                    tx_detect_rx <= 1'b1;
                                    state        <= WAIT_DET;
                                end
                            endcase
                        end
                    end
                end
                WAIT_PWR, WAIT_RATE, WAIT_DET: begin
                    // Electrical idle stays forced through the RESP cycle of a rate change.
                    if (state == WAIT_RATE) begin
                        tx_elec_idle <= ELEC_IDLE_ALL;
                    end
                    if (phy_status || timeout) begin
                        state        <= RESP;
                        ready_q      <= 1'b1;
                        done_q       <= 1'b1;
                        status_q     <= phy_status ? ST_OK : ST_TIMEOUT;
                        tx_detect_rx <= 1'b0;
                        if (state == WAIT_DET && phy_status) begin
                            detect_q <= (rx_status == RX_STATUS_DET);
                        end
                    end
                end
                default: begin
                    state <= RST_WAIT;
                end
            endcase
        end
    end

    assign req.req_ready     = ready_q;
    assign req.done          = done_q;
    assign req.done_status   = status_q;
    assign req.detect_result = detect_q;
endmodule

// File: tb/tb_pipe_pwr_rate_ctrl.sv
// Self-checking bench for pipe_pwr_rate_ctrl: directed scenarios then random commands vs. a reference model.
// Timeout scenarios are exercised when PIPE_PWR_RATE_CTRL_TIMEOUT_EN is defined.
module tb_pipe_pwr_rate_ctrl;
    localparam int MAX_RATE   = 4;
    localparam int TB_TIMEOUT = 16;
`ifdef PIPE_PWR_RATE_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] mac;
    logic       phy_status;
    logic [2:0] rx_status;
    logic [3:0] power_down;
    logic [3:0] rate;
    logic       tx_detect_rx;
    logic [3:0] tx_elec_idle;

    pipe_pwr_rate_ctrl_if bus();

    pipe_pwr_rate_ctrl #(
        .MAX_RATE       (MAX_RATE),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (bus),
        .mac_tx_elec_idle (mac),
        .phy_status       (phy_status),
        .rx_status        (rx_status),
        .power_down       (power_down),
        .rate             (rate),
        .tx_detect_rx     (tx_detect_rx),
        .tx_elec_idle     (tx_elec_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: architectural PHY-control state as seen from the LTSSM.
    int m_pd;
    int m_rate;
    int m_det;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Asserts reset mid-cycle, checks outputs at once, then runs the PHY's post-reset phy_status hold.
    task automatic do_reset(input int hold);
        #2;
        reset = 1'b1;
        phy_status = 1'b1;
        mac = 4'hF;
        bus.req_valid = 1'b0;
        #1;
        check("rst_pd",    int'(power_down),        2);
        check("rst_rate",  int'(rate),              0);
        check("rst_txdet", int'(tx_detect_rx),      0);
        check("rst_eidle", int'(tx_elec_idle),      15);
        check("rst_ready", int'(bus.req_ready),     0);
        check("rst_done",  int'(bus.done),          0);
        check("rst_stat",  int'(bus.done_status),   0);
        check("rst_det",   int'(bus.detect_result), 0);
        m_pd = 2; m_rate = 0; m_det = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rstwait_ready", int'(bus.req_ready), 0);
            check("rstwait_done",  int'(bus.done),      0);
        end
        phy_status = 1'b0;
        @(negedge clk);
        check("rstrel_ready", int'(bus.req_ready),  1);
        check("rstrel_pd",    int'(power_down),     2);
        check("rstrel_eidle", int'(tx_elec_idle),   15);
        check("rstrel_done",  int'(bus.done),       0);
    endtask

    // Issues one command from IDLE; d = cycles of phy_status low before the pulse.
    task automatic run_cmd(input int op, input int arg, input int d, input logic [2:0] rx,
                           input logic [3:0] mac_v, input bit coincide);
        int  st;
        bit  hs;
        bit  timed_out;
        int  w;
        int  eidle_busy;

        st = 0;
        hs = 1'b0;
        if (op == 3 || (op == 0 && arg > 3) || (op == 1 && arg > MAX_RATE)) st = 1;
        else if ((op == 1 && m_pd > 1) || (op == 2 && m_pd != 2)) st = 2;
        else if ((op == 0 && arg == m_pd) || (op == 1 && arg == m_rate)) st = 0;
        else hs = 1'b1;

        mac = mac_v;
        rx_status = rx;
        bus.req_valid = 1'b1;
        bus.req_op = 2'(op);
        bus.req_arg = 4'(arg);
        phy_status = coincide;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        phy_status = 1'b0;

        if (!hs) begin
            check("nohs_done",  int'(bus.done),          1);
            check("nohs_stat",  int'(bus.done_status),   st);
            check("nohs_ready", int'(bus.req_ready),     1);
            check("nohs_pd",    int'(power_down),        m_pd);
            check("nohs_rate",  int'(rate),              m_rate);
            check("nohs_eidle", int'(tx_elec_idle),      int'(mac_v));
            check("nohs_det",   int'(bus.detect_result), m_det);
            @(negedge clk);
            check("nohs_done_end", int'(bus.done), 0);
            return;
        end

        if (op == 0) m_pd = arg;
        if (op == 1) m_rate = arg;
        eidle_busy = (op == 1) ? 15 : int'(mac_v);
        check("acc_pd",    int'(power_down),    m_pd);
        check("acc_rate",  int'(rate),          m_rate);
        check("acc_txdet", int'(tx_detect_rx),  (op == 2) ? 1 : 0);
        check("acc_eidle", int'(tx_elec_idle),  eidle_busy);
        check("acc_ready", int'(bus.req_ready), 0);
        check("acc_done",  int'(bus.done),      0);

        timed_out = TO_EN && (d > TB_TIMEOUT - 1);
        w = timed_out ? TB_TIMEOUT - 1 : d;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            check("wait_done",  int'(bus.done),      0);
            check("wait_ready", int'(bus.req_ready), 0);
        end
        if (!timed_out) phy_status = 1'b1;
        @(negedge clk);
        phy_status = 1'b0;
        if (op == 2 && !timed_out) m_det = (rx == 3'b011) ? 1 : 0;
        check("resp_done",  int'(bus.done),          1);
        check("resp_stat",  int'(bus.done_status),   timed_out ? 3 : 0);
        check("resp_ready", int'(bus.req_ready),     1);
        check("resp_det",   int'(bus.detect_result), m_det);
        check("resp_txdet", int'(tx_detect_rx),      0);
        check("resp_eidle", int'(tx_elec_idle),      eidle_busy);
        check("resp_pd",    int'(power_down),        m_pd);
        check("resp_rate",  int'(rate),              m_rate);
        @(negedge clk);
        check("post_done",  int'(bus.done),      0);
        check("post_ready", int'(bus.req_ready), 1);
        check("post_eidle", int'(tx_elec_idle),  int'(mac_v));
    endtask

    initial begin
        reset = 1'b1;
        phy_status = 1'b1;
        rx_status = 3'b000;
        mac = 4'hF;
        bus.req_valid = 1'b0;
        bus.req_op = 2'd0;
        bus.req_arg = 4'd0;
        m_pd = 2; m_rate = 0; m_det = 0;

        do_reset(20);

        run_cmd(0, 0, 4, 3'b000, 4'hF, 1'b0);
        run_cmd(0, 2, 0, 3'b000, 4'hF, 1'b0);
        run_cmd(2, 0, 2, 3'b011, 4'hF, 1'b0);
        run_cmd(2, 0, 1, 3'b000, 4'hF, 1'b0);
        run_cmd(0, 0, 0, 3'b000, 4'h0, 1'b1);
        run_cmd(1, 3, 2, 3'b000, 4'h0, 1'b0);
        run_cmd(1, 5, 0, 3'b000, 4'h0, 1'b0);
        run_cmd(1, 3, 0, 3'b000, 4'h0, 1'b0);
        run_cmd(3, 0, 0, 3'b000, 4'h5, 1'b0);
        run_cmd(2, 0, 0, 3'b011, 4'h5, 1'b0);
        run_cmd(0, 2, 1, 3'b000, 4'hA, 1'b0);
        run_cmd(1, 1, 0, 3'b000, 4'hA, 1'b0);
        run_cmd(0, 2, 0, 3'b000, 4'hA, 1'b0);
        run_cmd(0, 7, 0, 3'b000, 4'hA, 1'b0);
        if (TO_EN) begin
            run_cmd(0, 3, TB_TIMEOUT + 3, 3'b000, 4'h3, 1'b0);
            run_cmd(0, 1, TB_TIMEOUT - 1, 3'b000, 4'h3, 1'b0);
            run_cmd(0, 2, TB_TIMEOUT - 2, 3'b000, 4'h3, 1'b0);
        end

        // Reset in the middle of a POWER handshake: no done may follow.
        bus.req_valid = 1'b1;
        bus.req_op = 2'd0;
        bus.req_arg = 4'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("midop_pd", int'(power_down), 3);
        @(negedge clk);
        do_reset(5);

        for (int n = 0; n < 200; n++) begin
            int op;
            int arg;
            int d;
            logic [2:0] rx;
            op  = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 3));
            arg = int'($urandom_range(0, 6));
            d   = int'($urandom_range(0, TO_EN ? 20 : 6));
            rx  = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
            run_cmd(op, arg, d, rx, 4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                phy_status = 1'b1;
                @(negedge clk);
                phy_status = 1'b0;
                check("idle_phy_done",  int'(bus.done),      0);
                check("idle_phy_ready", int'(bus.req_ready), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
